// File: rtl/const_div_seq.sv
// Iterative unsigned divide by constant DIVISOR, CHUNK dividend bits per cycle via an elaborated digit/remainder table.
// Latency: out_valid rises STEPS edges after the accepting edge; initiation interval STEPS+2 cycles minimum.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until the result is taken.
module const_div_seq #(
    parameter int WIDTH   = 16,
    parameter int DIVISOR = 11,
    parameter int CHUNK   = 2,
    parameter int TAG_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_dvd,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_quot,
    output logic [$clog2(DIVISOR)-1:0]  out_rem,
    output logic [TAG_W-1:0]            out_tag
);
    localparam int RW    = $clog2(DIVISOR);
    localparam int STEPS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW    = STEPS * CHUNK;
    localparam int TW    = RW + CHUNK;
    localparam int NE    = 1 << TW;
    localparam int CW    = $clog2(STEPS + 1);

    if (CHUNK < 1 || CHUNK > 6 || DIVISOR < 2 || RW + CHUNK > 8 || WIDTH < 2 || TAG_W < 1 ||
        (WIDTH < 31 && DIVISOR >= (1 << WIDTH))) begin : g_bad_params
        $error("const_div_seq: illegal parameter set");
    end

    // Entry t holds {t / DIVISOR, t % DIVISOR}, found by repeated subtraction.
    // Digits of unreachable entries (t >= DIVISOR << CHUNK) are simply truncated.
    function automatic logic [NE*TW-1:0] build_lut();
        logic [NE*TW-1:0] v;
        int r;
        int d;
        v = '0;
        for (int t = 0; t < NE; t++) begin
            r = t;
            d = 0;
            while (r >= DIVISOR) begin
                r = r - DIVISOR;
                d = d + 1;
            end
            v[t*TW +: TW] = {d[CHUNK-1:0], r[RW-1:0]};
        end
        return v;
    endfunction

    localparam logic [NE*TW-1:0] LUT = build_lut();

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   dvd_sh;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   lut_idx;
    logic [TW-1:0]   lut_entry;
    logic [CHUNK-1:0] lut_digit;
    logic [RW-1:0]   lut_rem;

    assign lut_idx   = {out_rem, dvd_sh[PW-1 -: CHUNK]};
    assign lut_entry = LUT[int'(lut_idx)*TW +: TW];
    assign lut_digit = lut_entry[TW-1 -: CHUNK];
    assign lut_rem   = lut_entry[RW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (cnt == CW'(STEPS - 1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state so every output comes from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_rem   <= '0;
            out_tag   <= '0;
            dvd_sh    <= '0;
            cnt       <= '0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_sh   <= PW'(in_dvd);
                        out_tag  <= in_tag;
                        out_rem  <= '0;
                        out_quot <= '0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    out_rem  <= lut_rem;
                    out_quot <= WIDTH'({out_quot, lut_digit});
                    dvd_sh   <= dvd_sh << CHUNK;
                    cnt      <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_const_div_seq.sv
// Bench for const_div_seq: several parameter sets side by side, directed cases plus a randomized sweep
// checked against plain integer division.
module tb_const_div_seq;
    localparam int NI = 8;
    localparam int PW_A [NI] = '{16, 13, 8, 12, 10, 16, 2, 9};
    localparam int PD_A [NI] = '{11, 7, 3, 100, 2, 5, 3, 37};
    localparam int PC_A [NI] = '{2, 3, 1, 1, 6, 5, 6, 2};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sv_valid     [NI];
    logic        sv_in_ready  [NI];
    logic        sv_out_valid [NI];
    logic        sv_out_ready [NI];
    logic [15:0] sv_dvd       [NI];
    logic [15:0] sv_quot      [NI];
    logic [7:0]  sv_rem       [NI];
    logic [3:0]  sv_tag       [NI];
    logic [3:0]  sv_otag      [NI];

    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = PW_A[g];
        localparam int D = PD_A[g];
        localparam int C = PC_A[g];
        localparam int R = $clog2(D);
        logic [W-1:0] q;
        logic [R-1:0] r;
        logic [3:0]   t;
        const_div_seq #(.WIDTH(W), .DIVISOR(D), .CHUNK(C), .TAG_W(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sv_valid[g]),
            .in_ready  (sv_in_ready[g]),
            .in_dvd    (sv_dvd[g][W-1:0]),
            .in_tag    (sv_tag[g]),
            .out_valid (sv_out_valid[g]),
            .out_ready (sv_out_ready[g]),
            .out_quot  (q),
            .out_rem   (r),
            .out_tag   (t)
        );
        assign sv_quot[g] = 16'(q);
        assign sv_rem[g]  = 8'(r);
        assign sv_otag[g] = t;
    end

    // Offers one operand to instance g and waits for its result; no checking here.
    task automatic do_op(input int g, input logic [15:0] dvd, input logic [3:0] tag,
                         output int lat, output bit rdy_low, output bit ok);
        int w;
        ok = 1'b1;
        rdy_low = 1'b1;
        lat = 0;
        w = 0;
        while (sv_in_ready[g] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) ok = 1'b0;
        sv_valid[g] = 1'b1;
        sv_dvd[g]   = dvd;
        sv_tag[g]   = tag;
        @(negedge clk);
        sv_valid[g] = 1'b0;
        while (sv_out_valid[g] !== 1'b1 && lat < 200) begin
            if (sv_in_ready[g] !== 1'b0) rdy_low = 1'b0;
            sv_dvd[g] = 16'($urandom);
            sv_tag[g] = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        if (sv_in_ready[g] !== 1'b0) rdy_low = 1'b0;
        if (lat >= 200) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            sv_valid[g] = 1'b0;
            sv_out_ready[g] = 1'b0;
            sv_dvd[g] = '0;
            sv_tag[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (sv_in_ready[g] !== 1'b1) begin failures++; $display("FAIL reset_in_ready inst=%0d got=%b exp=1", g, sv_in_ready[g]); end
            checks++;
            if (sv_out_valid[g] !== 1'b0) begin failures++; $display("FAIL reset_out_valid inst=%0d got=%b exp=0", g, sv_out_valid[g]); end
            checks++;
            if (sv_quot[g] !== 16'd0) begin failures++; $display("FAIL reset_quot inst=%0d got=%0d exp=0", g, sv_quot[g]); end
            checks++;
            if (sv_rem[g] !== 8'd0) begin failures++; $display("FAIL reset_rem inst=%0d got=%0d exp=0", g, sv_rem[g]); end
            checks++;
            if (sv_otag[g] !== 4'd0) begin failures++; $display("FAIL reset_tag inst=%0d got=%0d exp=0", g, sv_otag[g]); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat; bit rl; bit ok;
        do_op(0, 16'd65535, 4'd5, lat, rl, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout got=timeout exp=result"); end
        checks++;
        if (lat != 8) begin failures++; $display("FAIL single_latency got=%0d exp=8", lat); end
        checks++;
        if (sv_quot[0] !== 16'd5957) begin failures++; $display("FAIL single_quot got=%0d exp=5957", sv_quot[0]); end
        checks++;
        if (sv_rem[0] !== 8'd8) begin failures++; $display("FAIL single_rem got=%0d exp=8", sv_rem[0]); end
        checks++;
        if (sv_otag[0] !== 4'd5) begin failures++; $display("FAIL single_tag got=%0d exp=5", sv_otag[0]); end
        sv_out_ready[0] = 1'b1;
        @(negedge clk);
        sv_out_ready[0] = 1'b0;
        checks++;
        if (sv_out_valid[0] !== 1'b0 || sv_in_ready[0] !== 1'b1) begin
            failures++; $display("FAIL single_release got=vld%b/rdy%b exp=vld0/rdy1", sv_out_valid[0], sv_in_ready[0]);
        end
    endtask

    task automatic test_sequence();
        int vals [4] = '{0, 10, 11, 12345};
        int eq   [4] = '{0, 0, 1, 1122};
        int er   [4] = '{0, 10, 0, 3};
        int lat; bit rl; bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(0, 16'(vals[i]), 4'(i + 1), lat, rl, ok);
            checks++;
            if (!ok || lat != 8) begin failures++; $display("FAIL seq_latency idx=%0d got=%0d exp=8", i, lat); end
            checks++;
            if (!rl) begin failures++; $display("FAIL seq_in_ready idx=%0d got=high exp=low_until_handshake", i); end
            checks++;
            if (sv_quot[0] !== 16'(eq[i]) || sv_rem[0] !== 8'(er[i])) begin
                failures++; $display("FAIL seq_result idx=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, sv_quot[0], sv_rem[0], eq[i], er[i]);
            end
            checks++;
            if (sv_otag[0] !== 4'(i + 1)) begin failures++; $display("FAIL seq_tag idx=%0d got=%0d exp=%0d", i, sv_otag[0], i + 1); end
            sv_out_ready[0] = 1'b1;
            @(negedge clk);
            sv_out_ready[0] = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int lat; bit rl; bit ok;
        int dv;
        dv = int'($urandom_range(0, 65535));
        do_op(0, 16'(dv), 4'd9, lat, rl, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_timeout got=timeout exp=result"); end
        // A waiting operand must not be taken while the result is held.
        sv_valid[0] = 1'b1;
        sv_dvd[0] = 16'd777;
        sv_tag[0] = 4'd3;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (sv_out_valid[0] !== 1'b1 || sv_in_ready[0] !== 1'b0) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=vld%b/rdy%b exp=vld1/rdy0", c, sv_out_valid[0], sv_in_ready[0]);
            end
            checks++;
            if (sv_quot[0] !== 16'(dv / 11) || sv_rem[0] !== 8'(dv % 11) || sv_otag[0] !== 4'd9) begin
                failures++; $display("FAIL bp_stable cyc=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,9)", c, sv_quot[0], sv_rem[0], sv_otag[0], dv / 11, dv % 11);
            end
        end
        sv_out_ready[0] = 1'b1;
        @(negedge clk);
        sv_out_ready[0] = 1'b0;
        sv_valid[0] = 1'b0;
        checks++;
        if (sv_out_valid[0] !== 1'b0 || sv_in_ready[0] !== 1'b1) begin
            failures++; $display("FAIL bp_release got=vld%b/rdy%b exp=vld0/rdy1", sv_out_valid[0], sv_in_ready[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        sv_valid[0] = 1'b1;
        sv_dvd[0] = 16'd1000;
        sv_tag[0] = 4'd7;
        @(negedge clk);
        sv_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (sv_in_ready[0] !== 1'b1 || sv_out_valid[0] !== 1'b0) begin
            failures++; $display("FAIL rstmid_flags got=rdy%b/vld%b exp=rdy1/vld0", sv_in_ready[0], sv_out_valid[0]);
        end
        checks++;
        if (sv_quot[0] !== 16'd0 || sv_rem[0] !== 8'd0 || sv_otag[0] !== 4'd0) begin
            failures++; $display("FAIL rstmid_outputs got=(%0d,%0d,%0d) exp=(0,0,0)", sv_quot[0], sv_rem[0], sv_otag[0]);
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (sv_out_valid[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL rstmid_no_result got=out_valid exp=none"); end
    endtask

    task automatic test_padded();
        int lat; bit rl; bit ok;
        do_op(1, 16'd8191, 4'd2, lat, rl, ok);
        checks++;
        if (!ok || lat != 5) begin failures++; $display("FAIL padded_latency got=%0d exp=5", lat); end
        checks++;
        if (sv_quot[1] !== 16'd1170 || sv_rem[1] !== 8'd1 || sv_otag[1] !== 4'd2) begin
            failures++; $display("FAIL padded_result got=(%0d,%0d,%0d) exp=(1170,1,2)", sv_quot[1], sv_rem[1], sv_otag[1]);
        end
        sv_out_ready[1] = 1'b1;
        @(negedge clk);
        sv_out_ready[1] = 1'b0;
    endtask

    task automatic test_sweep();
        logic [3:0] tq [$];
        logic [3:0] et;
        int lat; bit rl; bit ok;
        int w, d, st, mask, dv, q, r;
        for (int g = 0; g < NI; g++) begin
            w = PW_A[g];
            d = PD_A[g];
            st = (w + PC_A[g] - 1) / PC_A[g];
            mask = (1 << w) - 1;
            for (int n = 0; n < 24; n++) begin
                if (n == 0) dv = 0;
                else if (n == 1) dv = mask;
                else dv = int'($urandom) & mask;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sv_out_ready[g] = 1'($urandom_range(0, 1));
                et = 4'($urandom);
                tq.push_back(et);
                do_op(g, 16'(dv), et, lat, rl, ok);
                q = int'(sv_quot[g]);
                r = int'(sv_rem[g]);
                checks++;
                if (!ok || lat != st) begin failures++; $display("FAIL sweep_latency inst=%0d got=%0d exp=%0d", g, lat, st); end
                checks++;
                if (q != dv / d || r != dv % d) begin
                    failures++; $display("FAIL sweep_result inst=%0d dvd=%0d got=(%0d,%0d) exp=(%0d,%0d)", g, dv, q, r, dv / d, dv % d);
                end
                checks++;
                if (q * d + r != dv || r >= d) begin
                    failures++; $display("FAIL sweep_identity inst=%0d dvd=%0d got=q*d+r=%0d,r=%0d exp=%0d,<%0d", g, dv, q * d + r, r, dv, d);
                end
                et = tq.pop_front();
                checks++;
                if (sv_otag[g] !== et) begin failures++; $display("FAIL sweep_tag inst=%0d got=%0d exp=%0d", g, sv_otag[g], et); end
                if (sv_out_ready[g] !== 1'b1) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    sv_out_ready[g] = 1'b1;
                end
                @(negedge clk);
                sv_out_ready[g] = 1'b0;
                checks++;
                if (sv_out_valid[g] !== 1'b0) begin failures++; $display("FAIL sweep_release inst=%0d got=vld%b exp=vld0", g, sv_out_valid[g]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_backpressure();
        test_reset_mid();
        test_padded();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
